// File: rtl/pos_embed_add.sv
// pos_embed_add: adds a learned positional-embedding table to the embedded-patch
// stream and forwards tokens one element per beat through a single output slot.
// Optional class-token prepend is built when the macro POS_EMBED_CLS_EN is defined.
module pos_embed_add #(
   parameter  int DATA_WIDTH  = 16,
   parameter  int NUM_PATCHES = 196,
   parameter  int E           = 128,
`ifdef POS_EMBED_CLS_EN
   localparam int CLS         = 1,
`else
   localparam int CLS         = 0,
`endif
   localparam int TOKENS      = NUM_PATCHES + CLS,
   localparam int AW          = $clog2(TOKENS * E)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic                    pos_wr_en,
   input  logic [AW-1:0]           pos_wr_addr,
   input  logic [DATA_WIDTH-1:0]   pos_wr_data,
   input  logic [DATA_WIDTH*E-1:0] cls_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_last
);

   localparam int DEPTH = TOKENS * E;
   localparam int TW    = $clog2(TOKENS + 1);
   localparam int DIMW  = $clog2(E + 1);

   localparam logic [TW-1:0]         TOK_LAST = TW'(TOKENS - 1);
   localparam logic [DIMW-1:0]       DIM_LAST = DIMW'(E - 1);
   localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

`ifdef POS_EMBED_CLS_EN
   typedef enum logic [2:0] {S_IDLE, S_CLS, S_STREAM, S_DRAIN, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;
`endif

   state_t                state;
   state_t                state_nx;
   logic [TW-1:0]         tok;
   logic [DIMW-1:0]       dim;
   logic [DATA_WIDTH-1:0] pos_mem [DEPTH];
   logic [AW-1:0]         rd_addr;
   logic [DATA_WIDTH-1:0] pos_rd;
   logic [DATA_WIDTH-1:0] src;
   logic [DATA_WIDTH-1:0] cls_sel;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] sat;
   logic                  slot_free;
   logic                  load;
   logic                  is_last;
   logic                  wr_ok;

`ifdef POS_EMBED_CLS_EN
   assign cls_sel = cls_in[int'(dim)*DATA_WIDTH +: DATA_WIDTH];
`else
   logic cls_unused;
   assign cls_unused = ^cls_in;
   assign cls_sel    = '0;
`endif

   assign slot_free = !out_valid || out_ready;
   assign is_last   = (tok == TOK_LAST) && (dim == DIM_LAST);
   assign rd_addr   = AW'(int'(tok) * E + int'(dim));
   assign pos_rd    = pos_mem[rd_addr];
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign wr_ok     = pos_wr_en && (state == S_IDLE) &&
                      ({1'b0, pos_wr_addr} < (AW+1)'(DEPTH));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state, source selection and input handshake
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      in_ready = 1'b0;
      src      = in_data;
      case (state)
         S_IDLE: begin
            if (start) begin
`ifdef POS_EMBED_CLS_EN
               state_nx = S_CLS;
`else
               state_nx = S_STREAM;
`endif
            end
         end
`ifdef POS_EMBED_CLS_EN
         S_CLS: begin
            src = cls_sel;
            if (slot_free) begin
               load = 1'b1;
               if (dim == DIM_LAST) state_nx = S_STREAM;
            end
         end
`endif
         S_STREAM: begin
            in_ready = slot_free;
            if (slot_free && in_valid) begin
               load = 1'b1;
               if (is_last) state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_valid && out_ready) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Signed widened add with saturation to the element range
   always_comb begin
      sum = {src[DATA_WIDTH-1], src} + {pos_rd[DATA_WIDTH-1], pos_rd};
      sat = sum[DATA_WIDTH-1:0];
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) sat = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
   end

   // Output slot and token/dimension counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         tok       <= '0;
         dim       <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= sat;
         out_last  <= is_last;
         if (dim == DIM_LAST) begin
            dim <= '0;
            tok <= is_last ? '0 : tok + 1'b1;
         end else begin
            dim <= dim + 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Positional table; contents survive reset, writable only while idle
   always_ff @(posedge clk) begin
      if (wr_ok) pos_mem[pos_wr_addr] <= pos_wr_data;
   end

endmodule

// File: tb/tb_pos_embed_add.sv
// tb_pos_embed_add: scoreboard bench for pos_embed_add (NUM_PATCHES=4, E=4, DW=16).
// Follows POS_EMBED_CLS_EN the same way as the design.
module tb_pos_embed_add;
   localparam int DW = 16;
   localparam int NP = 4;
   localparam int E  = 4;
`ifdef POS_EMBED_CLS_EN
   localparam int CLS = 1;
`else
   localparam int CLS = 0;
`endif
   localparam int TOKENS = NP + CLS;
   localparam int DEPTH  = TOKENS * E;
   localparam int AW     = $clog2(DEPTH);
   localparam int NIN    = NP * E;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic          pos_wr_en;
   logic [AW-1:0] pos_wr_addr;
   logic [DW-1:0] pos_wr_data;
   logic [DW*E-1:0] cls_in;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   pos_embed_add #(.DATA_WIDTH(DW), .NUM_PATCHES(NP), .E(E)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .pos_wr_en(pos_wr_en), .pos_wr_addr(pos_wr_addr), .pos_wr_data(pos_wr_data),
      .cls_in(cls_in), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int            n_vec  = 0;
   int            n_miss = 0;
   int            cyc    = 0;
   int            last_cycle = 0;
   bit            rnd_ready  = 1'b0;
   logic [DW:0]   exp_q [$];
   logic [DW-1:0] pos_tab [DEPTH];
   logic [DW-1:0] patch   [NIN];
   logic [DW-1:0] cls_val [E];

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream backpressure generator
   always @(posedge clk) begin
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, {26'd0, busy, done, in_ready, out_valid, out_last, 1'b0} | 32'(out_data != 0), 32'd0);
      check({name, "_data"}, 32'(out_data), 32'd0);
   endtask

   function automatic logic [DW-1:0] sat_add(input int a, input int b);
      int s;
      s = a + b;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return DW'(s);
   endfunction

   // Reference: every token element is sat(source + pos[token][dim])
   task automatic push_image();
      for (int t = 0; t < TOKENS; t++) begin
         for (int d = 0; d < E; d++) begin
            logic [DW-1:0] s;
            int p;
            p = t - CLS;
            if (p < 0) s = cls_val[d];
            else       s = patch[p*E + d];
            exp_q.push_back({(t == TOKENS-1) && (d == E-1),
                             sat_add(int'($signed(s)), int'($signed(pos_tab[t*E + d])))});
         end
      end
   endtask

   task automatic load_cls();
      for (int d = 0; d < E; d++) cls_in[d*DW +: DW] = cls_val[d];
   endtask

   task automatic write_table();
      for (int a = 0; a < DEPTH; a++) begin
         pos_wr_en   = 1'b1;
         pos_wr_addr = AW'(a);
         pos_wr_data = pos_tab[a];
         @(posedge clk); #1;
      end
      pos_wr_en = 1'b0;
   endtask

   task automatic feed(input bit rnd_valid, input bit noise, input int lim);
      int  i = 0;
      int  guard = 0;
      bit  acc;
      while (i < lim && guard < 2000) begin
         in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = patch[i];
         if (noise) begin
            pos_wr_en   = 1'($urandom_range(0, 1));
            pos_wr_addr = AW'($urandom);
            pos_wr_data = DW'($urandom);
            start       = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
      end
      in_valid  = 1'b0;
      pos_wr_en = 1'b0;
      start     = 1'b0;
      if (guard >= 2000) check("feed_timeout", 32'(i), 32'(lim));
   endtask

   task automatic run_image(input bit rnd_valid, input bit noise, input int lim);
      int g;
      push_image();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      if (CLS == 1) begin
         for (int k = 0; k < E; k++) begin
            @(negedge clk);
            check("in_ready_cls", 32'(in_ready), 32'd0);
         end
         @(posedge clk); #1;
      end
      feed(rnd_valid, noise, lim);
      if (lim < NIN) return;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!done && g < 300);
      check("done_seen", 32'(done), 32'd1);
      check("done_timing", 32'(cyc), 32'(last_cycle + 1));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      check("idle_in_ready", 32'(in_ready), 32'd0);
   endtask

   // Monitor: pop expected on each output handshake; hold-check on stalls
   bit            stalled = 1'b0;
   logic [DW:0]   held;
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) check("stall_hold", {15'd0, out_valid, out_last, out_data}, {15'd0, 1'b1, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(exp_q.size()), 32'd1);
            end else begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               check("out_beat", {15'd0, out_last, out_data}, {15'd0, e});
               if (e[DW]) last_cycle = cyc;
            end
         end
         stalled = out_valid && !out_ready;
         held    = {out_last, out_data};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; pos_wr_en = 1'b0; pos_wr_addr = '0; pos_wr_data = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      for (int d = 0; d < E; d++) cls_val[d] = 16'd7;
      load_cls();
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ramp table and ramp patches (with class token 7 when enabled)
      for (int a = 0; a < DEPTH; a++) pos_tab[a] = DW'(a);
      for (int i = 0; i < NIN; i++) patch[i] = DW'(100 + i);
      write_table();
      run_image(1'b0, 1'b0, NIN);

      // Saturation at both rails
      for (int a = 0; a < DEPTH; a++) pos_tab[a] = DW'($urandom);
      pos_tab[CLS*E]     = 16'h0100;
      pos_tab[CLS*E + 1] = 16'hFF00;
      for (int i = 0; i < NIN; i++) patch[i] = DW'($urandom);
      patch[0] = 16'h7FF0;
      patch[1] = 16'h8010;
      write_table();
      run_image(1'b0, 1'b0, NIN);

      // Random data with random valid and backpressure
      rnd_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < DEPTH; a++)
            pos_tab[a] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000)
                                                     : DW'($urandom);
         for (int i = 0; i < NIN; i++) patch[i] = DW'($urandom);
         for (int d = 0; d < E; d++) cls_val[d] = DW'($urandom);
         load_cls();
         write_table();
         run_image(1'b1, 1'b0, NIN);
      end
      rnd_ready = 1'b0;

      // Table writes and start pulses while busy must be ignored
      for (int a = 0; a < DEPTH; a++) pos_tab[a] = DW'(a);
      for (int i = 0; i < NIN; i++) patch[i] = DW'(100 + i);
      for (int d = 0; d < E; d++) cls_val[d] = 16'd7;
      load_cls();
      write_table();
      run_image(1'b0, 1'b1, NIN);
      run_image(1'b0, 1'b0, NIN);

      // Reset mid-image, then a clean rerun on the retained table
      run_image(1'b0, 1'b0, 6);
      rst_n = 1'b0;
      #1;
      check_idle("reset_mid");
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("after_reset");
      run_image(1'b0, 1'b0, NIN);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
